// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: FSM encoding and
// default geometry/latency parameters.
package data_mem_ctrl_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DEPTH    = 256;
    localparam int DEF_READ_LAT = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem_ctrl_mem_array.sv
// DEPTH x DATA_W RAM: one write port, synchronous read port with an output
// register that can load zero instead of the array word.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array; contents are initialised by the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read samples the pre-write contents, giving read-before-write on a
    // same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: zero-fills the RAM after reset, then serves
// range-checked reads/writes with a READ_LAT-cycle read pipeline.
//
// state | meaning
// CLEAR | writing zero at clr_cnt each cycle, busy=1, requests ignored
// READY | accepting read/write requests
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        address,
    input  logic signed [DATA_W-1:0] write_data,
    input  logic                     r_flag,
    input  logic                     w_flag,
    output logic signed [DATA_W-1:0] read_data,
    output logic                     read_valid,
    output logic                     busy,
    output logic                     addr_fault
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("data_mem_ctrl: READ_LAT must be 1 or 2");
    end
    if (DEPTH < 2 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
        $error("data_mem_ctrl: DEPTH must be in 2 .. 2**ADDR_W");
    end

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  clr_cnt, clr_cnt_nxt;
    logic              in_range;
    logic              req_acc;
    logic              rd_acc;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [READ_LAT-1:0] rd_vld;

    // Zero-extend so an address equal to 2**ADDR_W-1 never aliases DEPTH.
    assign in_range = {1'b0, address} < DEPTH_EXT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        mem_we      = 1'b0;
        mem_waddr   = address[IDX_W-1:0];
        mem_wdata   = write_data;
        req_acc     = 1'b0;
        rd_acc      = 1'b0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = '0;
                if (clr_cnt == LAST_IDX) begin
                    state_nxt   = READY;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            READY: begin
                req_acc = r_flag | w_flag;
                rd_acc  = r_flag;
                mem_we  = w_flag & in_range;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign busy = (state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_fault <= 1'b0;
        end else begin
            addr_fault <= req_acc & ~in_range;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_acc),
        .rzero (~in_range),
        .raddr (address[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    // The RAM output register is the first latency stage; a second stage
    // is added only for READ_LAT=2 and loads only on valid data so
    // read_data holds between results.
    if (READ_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_vld <= '0;
            end else begin
                rd_vld <= rd_acc;
            end
        end
        assign read_data = ram_rdata;
    end else begin : g_lat2
        logic [DATA_W-1:0] rd_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_vld <= '0;
                rd_q   <= '0;
            end else begin
                rd_vld <= {rd_vld[0], rd_acc};
                if (rd_vld[0]) begin
                    rd_q <= ram_rdata;
                end
            end
        end
        assign read_data = rd_q;
    end

    assign read_valid = rd_vld[READ_LAT-1];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: READ_LAT=1 and READ_LAT=2 instances share the
// same stimulus; read/fault expectations go through due-cycle scoreboards.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = '0;
    logic [15:0] write_data = '0;
    logic        r_flag = 1'b0;
    logic        w_flag = 1'b0;
    logic [15:0] rd1, rd2;
    logic        rv1, rv2, busy1, busy2, af1, af2;

    always #5 clk = ~clk;

    data_mem_ctrl #(.READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .r_flag(r_flag), .w_flag(w_flag), .read_data(rd1), .read_valid(rv1),
        .busy(busy1), .addr_fault(af1)
    );

    data_mem_ctrl #(.READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .r_flag(r_flag), .w_flag(w_flag), .read_data(rd2), .read_valid(rv2),
        .busy(busy2), .addr_fault(af2)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        bit          r;
        bit          w;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] erd;
        bit          ef;
    } vec_t;

    exp_t        q1[$];
    exp_t        q2[$];
    int          fq[$];
    logic [15:0] mem_m [256];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Output monitor: compares read_valid/read_data/addr_fault at due cycles.
    bit e1, e2, ef;
    always @(negedge clk) begin
        if (!rst) begin
            e1 = (q1.size() > 0) && (q1[0].due == cyc);
            if (rv1 || e1) begin
                check("lat1 read_valid", rv1, e1);
                if (rv1 && e1) check("lat1 read_data", rd1, q1[0].data);
            end
            if (e1) void'(q1.pop_front());
            e2 = (q2.size() > 0) && (q2[0].due == cyc);
            if (rv2 || e2) begin
                check("lat2 read_valid", rv2, e2);
                if (rv2 && e2) check("lat2 read_data", rd2, q2[0].data);
            end
            if (e2) void'(q2.pop_front());
            ef = (fq.size() > 0) && (fq[0] == cyc);
            if (af1 || af2 || ef) begin
                check("lat1 addr_fault", af1, ef);
                check("lat2 addr_fault", af2, ef);
            end
            if (ef) void'(fq.pop_front());
        end
    end

    task automatic idle();
        r_flag = 1'b0;
        w_flag = 1'b0;
    endtask

    // One request cycle; expectations come from the table when use_exp is set,
    // otherwise from the reference memory.
    task automatic do_cycle(input bit r, input bit w, input logic [15:0] a,
                            input logic [15:0] wd, input bit use_exp,
                            input logic [15:0] erd, input bit efl);
        logic [15:0] e;
        bit          f;
        f = use_exp ? efl : ((r || w) && a >= 16'd256);
        e = use_exp ? erd : ((a < 16'd256) ? mem_m[a[7:0]] : 16'h0000);
        if (r) begin
            q1.push_back('{cyc + 1, e});
            q2.push_back('{cyc + 2, e});
        end
        if (f) fq.push_back(cyc + 1);
        if (w && a < 16'd256) mem_m[a[7:0]] = wd;
        r_flag = r;
        w_flag = w;
        address = a;
        write_data = wd;
        @(posedge clk);
        #1;
        idle();
    endtask

    // Counts cycles with busy high after release; optionally pokes requests
    // into the clear window, which must be ignored.
    task automatic busy_window(input string nm, input bit poke);
        int n1, n2;
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy1 && !busy2) break;
            if (busy1) n1++;
            if (busy2) n2++;
            if (poke && i >= 50 && i < 53) begin
                r_flag = 1'b1;
                w_flag = 1'b1;
                address = 16'd10;
                write_data = 16'h5555;
            end else begin
                idle();
            end
            @(posedge clk);
            #1;
        end
        idle();
        check({nm, " lat1 busy cycles"}, n1, 256);
        check({nm, " lat2 busy cycles"}, n2, 256);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        q1.delete();
        q2.delete();
        fq.delete();
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
    endtask

    vec_t tbl[23];

    initial begin
        tbl[0]  = '{0, 1, 16'd5,     16'h1234, 16'h0000, 0};
        tbl[1]  = '{1, 0, 16'd5,     16'h0000, 16'h1234, 0};
        tbl[2]  = '{0, 1, 16'd7,     16'h00AA, 16'h0000, 0};
        tbl[3]  = '{1, 1, 16'd7,     16'h0055, 16'h00AA, 0};
        tbl[4]  = '{1, 0, 16'd7,     16'h0000, 16'h0055, 0};
        tbl[5]  = '{0, 1, 16'd300,   16'hBEEF, 16'h0000, 1};
        tbl[6]  = '{1, 0, 16'd300,   16'h0000, 16'h0000, 1};
        tbl[7]  = '{1, 0, 16'd44,    16'h0000, 16'h0000, 0};
        tbl[8]  = '{0, 1, 16'd1,     16'h0011, 16'h0000, 0};
        tbl[9]  = '{0, 1, 16'd2,     16'h0022, 16'h0000, 0};
        tbl[10] = '{0, 1, 16'd3,     16'h0033, 16'h0000, 0};
        tbl[11] = '{1, 0, 16'd1,     16'h0000, 16'h0011, 0};
        tbl[12] = '{1, 0, 16'd2,     16'h0000, 16'h0022, 0};
        tbl[13] = '{1, 0, 16'd3,     16'h0000, 16'h0033, 0};
        tbl[14] = '{0, 0, 16'd0,     16'h0000, 16'h0000, 0};
        tbl[15] = '{0, 1, 16'd255,   16'h8001, 16'h0000, 0};
        tbl[16] = '{1, 0, 16'd255,   16'h0000, 16'h8001, 0};
        tbl[17] = '{1, 0, 16'd256,   16'h0000, 16'h0000, 1};
        tbl[18] = '{0, 1, 16'd65535, 16'h7777, 16'h0000, 1};
        tbl[19] = '{1, 0, 16'd65535, 16'h0000, 16'h0000, 1};
        tbl[20] = '{1, 0, 16'd255,   16'h0000, 16'h8001, 0};
        tbl[21] = '{1, 1, 16'd256,   16'h0001, 16'h0000, 1};
        tbl[22] = '{1, 0, 16'd2,     16'h0000, 16'h0022, 0};

        assert_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset lat1 read_data", rd1, 16'h0000);
        check("reset lat1 read_valid", rv1, 1'b0);
        check("reset lat1 addr_fault", af1, 1'b0);
        check("reset lat1 busy", busy1, 1'b1);
        check("reset lat2 read_data", rd2, 16'h0000);
        check("reset lat2 read_valid", rv2, 1'b0);
        check("reset lat2 busy", busy2, 1'b1);
        rst = 1'b0;

        busy_window("initial clear", 1'b1);

        for (int a = 0; a < 256; a++) do_cycle(1'b1, 1'b0, 16'(a), 16'h0, 1'b0, 16'h0, 1'b0);
        repeat (3) do_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);

        foreach (tbl[i]) do_cycle(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, 1'b1, tbl[i].erd, tbl[i].ef);

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("hold lat1 read_data", rd1, 16'h0022);
        check("hold lat2 read_data", rd2, 16'h0022);
        check("hold lat1 read_valid", rv1, 1'b0);
        check("hold lat2 read_valid", rv2, 1'b0);
        check("queues drained", q1.size() + q2.size() + fq.size(), 0);

        // Reset while the READ_LAT=2 result is still in flight.
        q1.push_back('{cyc + 1, 16'h1234});
        r_flag = 1'b1;
        address = 16'd5;
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        #1;
        assert_reset();
        #1;
        check("mid-read lat2 read_valid", rv2, 1'b0);
        check("mid-read lat2 read_data", rd2, 16'h0000);
        check("mid-read lat1 read_data", rd1, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        busy_window("after mid-read reset", 1'b0);

        // Reset with the clear counter at 100.
        assert_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("mid-clear lat1 busy", busy1, 1'b1);
        rst = 1'b1;
        #1;
        check("mid-clear reset busy", busy2, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        busy_window("after mid-clear reset", 1'b0);

        do_cycle(1'b1, 1'b0, 16'd5, 16'h0, 1'b0, 16'h0, 1'b0);
        do_cycle(1'b1, 1'b0, 16'd255, 16'h0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (q1.size() == 0 && q2.size() == 0 && fq.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("final queues drained", q1.size() + q2.size() + fq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16: address bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 256: number of words; 2 <= DEPTH <= 2^ADDR_W.
REQ-004 SHALL have parameter READ_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port address, input, ADDR_W bits: word address of the request.
REQ-008 SHALL have port write_data, input, DATA_W bits, signed: data to write.
REQ-009 SHALL have port r_flag, input, 1 bit: read request, sampled each cycle.
REQ-010 SHALL have port w_flag, input, 1 bit: write request, sampled each cycle.
REQ-011 SHALL have port read_data, output, DATA_W bits, signed: registered read result.
REQ-012 SHALL have port read_valid, output, 1 bit: read_data is valid this cycle.
REQ-013 SHALL have port busy, output, 1 bit: initialisation in progress; requests are ignored.
REQ-014 SHALL have port addr_fault, output, 1 bit: one-cycle pulse flagging an out-of-range request.

Function
REQ-015 SHALL implement a two-state FSM, CLEAR and READY; reset enters CLEAR with clear counter 0.
REQ-016 In CLEAR: SHALL write zero at counter address each cycle and increment; after writing DEPTH-1 SHALL enter READY next cycle; busy=1 for exactly DEPTH cycles.
REQ-017 In CLEAR: r_flag/w_flag SHALL be ignored: no write, no read_valid, no addr_fault.
REQ-018 In READY: a request is accepted when r_flag or w_flag is 1 in a cycle with busy=0.
REQ-019 Accepted write with address < DEPTH SHALL update mem[address] at that clock edge.
REQ-020 Accepted read SHALL assert read_valid exactly READ_LAT cycles after the request edge, with read_data = mem[address] at request time.
REQ-021 r_flag and w_flag both 1 at one address SHALL be read-before-write: read returns old data, write commits.
REQ-022 Write at cycle N followed by read of same address at cycle N+1 SHALL return the new data.
REQ-023 Back-to-back reads SHALL be fully pipelined: one result per cycle, in order, no bubbles.
REQ-024 Request with address >= DEPTH: write SHALL be dropped and addr_fault SHALL pulse one cycle after the request.
REQ-025 Out-of-range read SHALL still produce read_valid at READ_LAT with read_data = 0.
REQ-026 When read_valid=0, read_data SHALL hold its last value.
REQ-027 Address comparison SHALL be unsigned on the full ADDR_W bits; no wrap or truncation.

Reset
REQ-028 On rst=1, asynchronously: read_data=0, read_valid=0, addr_fault=0, busy=1, state=CLEAR, counter=0, read pipeline valid bits cleared.
REQ-029 Reset asserted mid-clear or mid-read SHALL discard in-flight reads and restart the full clear sequence after release.
REQ-030 Memory array SHALL NOT have a reset; it is zeroed only by the CLEAR sequence.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (CLEAR, READY) and the default values for DATA_W, ADDR_W, DEPTH and READ_LAT.
REQ-032 SHALL have one sub-module mem_array: a single-port-write, synchronous-read RAM of DEPTH x DATA_W. The FSM, range check and latency pipeline SHALL live in data_mem_ctrl.
REQ-033 Elaboration SHALL fail on READ_LAT not in {1,2} or DEPTH > 2^ADDR_W.

Verification
REQ-034 Reset release, DEPTH=256 -> busy=1 for 256 cycles then 0; reading addr 0..255 returns 0 each.
REQ-035 READ_LAT=2: write 0x1234 to addr 5, read addr 5 next cycle -> read_valid and 0x1234 two cycles after the read.
REQ-036 Simultaneous r_flag=w_flag=1, addr 7 holds 0x00AA, write_data=0x0055 -> read returns 0x00AA; next read returns 0x0055.
REQ-037 Write 0xBEEF to addr 300 (DEPTH=256) -> addr_fault pulses 1 cycle; read of addr 300 returns 0 with addr_fault; addr 44 (300 mod 256) is unchanged.
REQ-038 Reads of 1, 2, 3 on consecutive cycles after writing 0x0011/0x0022/0x0033 -> three consecutive read_valid cycles, data in order.
REQ-039 rst pulsed during clear counter=100 and during an in-flight read -> no read_valid emitted; busy restarts for a full 256 cycles.
